// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction-memory
// req/gnt/rvalid channel and the valid/ready link to decode.
interface fetch_unit_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_ready_i;

  modport master (
    input  redirect_i,
    input  redirect_pc_i,
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    output if_valid_o,
    output if_pc_o,
    output if_instr_o,
    input  if_ready_i
  );

  modport slave (
    output redirect_i,
    output redirect_pc_i,
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i,
    input  if_valid_o,
    input  if_pc_o,
    input  if_instr_o,
    output if_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited
// memory requests, instruction buffer and redirect flush/discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic         clk_i,
  input logic         rst_i,
  fetch_unit_if.master bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t        LAST  = ptr_t'(FIFO_DEPTH - 1);
  localparam logic [CW:0] LIMIT = (CW+1)'(FIFO_DEPTH);

  logic [31:0] fetch_pc;

  logic [31:0] buf_pc    [FIFO_DEPTH];
  logic [31:0] buf_instr [FIFO_DEPTH];
  ptr_t        buf_rd;
  ptr_t        buf_wr;
  cnt_t        buf_cnt;

  logic [31:0] tag_q [FIFO_DEPTH];
  ptr_t        tag_rd;
  ptr_t        tag_wr;

  cnt_t        outstanding;
  cnt_t        discard;

  logic [CW:0] used;
  logic        req;
  logic        grant;
  logic        resp;
  logic        drop;
  logic        push;
  logic        has;
  logic        valid;
  logic        pop;

  function automatic ptr_t inc(input ptr_t p);
    return (p == LAST) ? '0 : p + ptr_t'(1);
  endfunction

  // Credits count both in-flight requests and buffered entries, so
  // every granted request is guaranteed a buffer slot on return.
  assign used  = {1'b0, outstanding} + {1'b0, buf_cnt};
  assign req   = !rst_i && !bus.redirect_i && (used < LIMIT);
  assign grant = req && bus.imem_gnt_i;
  assign resp  = bus.imem_rvalid_i && (outstanding != '0);
  assign drop  = resp && (discard != '0);
  assign push  = resp && !drop;
  assign has   = (buf_cnt != '0);
  assign valid = has && !bus.redirect_i;
  assign pop   = valid && bus.if_ready_i;

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = fetch_pc;
  assign bus.if_valid_o  = valid;
  assign bus.if_pc_o     = has ? buf_pc[buf_rd] : '0;
  assign bus.if_instr_o  = has ? buf_instr[buf_rd] : '0;

  // Control state: pc, pointers, counters, redirect flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      buf_rd      <= '0;
      buf_wr      <= '0;
      buf_cnt     <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + cnt_t'(grant) - cnt_t'(resp);
      if (grant) tag_wr <= inc(tag_wr);
      if (resp)  tag_rd <= inc(tag_rd);
      if (bus.redirect_i) begin
        fetch_pc <= bus.redirect_pc_i & 32'hFFFF_FFFC;
        buf_rd   <= '0;
        buf_wr   <= '0;
        buf_cnt  <= '0;
        discard  <= outstanding - cnt_t'(resp);
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (drop)  discard  <= discard - cnt_t'(1);
        if (push)  buf_wr   <= inc(buf_wr);
        if (pop)   buf_rd   <= inc(buf_rd);
        buf_cnt <= buf_cnt + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // Storage: tag of each granted request, buffered {pc, instr}.
  always_ff @(posedge clk_i) begin
    if (grant) tag_q[tag_wr] <= fetch_pc;
    if (push && !bus.redirect_i) begin
      buf_pc[buf_wr]    <= tag_q[tag_rd];
      buf_instr[buf_wr] <= bus.imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model, expected-instruction
// queue filled by stimulus, monitor checks every accepted instruction.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC  (32'h0000_0080),
    .FIFO_DEPTH(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  int          checks  = 0;
  int          errors  = 0;
  int          gcnt    = 0;
  logic        resp_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = pc ^ 32'hA5A5_A5A5;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int n, input string name);
    int k = 0;
    int b = 0;
    @(posedge clk); #1;
    bus.imem_gnt_i = 1'b1;
    while (k < n && b < 200) begin
      @(negedge clk);
      b++;
      if (bus.imem_req_o && bus.imem_gnt_i) k++;
    end
    @(posedge clk); #1;
    bus.imem_gnt_i = 1'b0;
    if (k < n) fail(name);
  endtask

  task automatic drain(input string name);
    int b = 0;
    while (exp_q.size() > 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!bus.if_valid_o && b < 50);
    if (!bus.if_valid_o) fail(name);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    gcnt = 0;
    bus.imem_gnt_i = 1'b0;
    bus.if_ready_i = 1'b0;
    bus.redirect_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Memory: grant seen this cycle, response one cycle later, in order.
  initial begin
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_q.delete();
      end else if (bus.imem_req_o && bus.imem_gnt_i) begin
        mem_q.push_back(bus.imem_addr_o);
        gcnt++;
      end
      @(posedge clk); #1;
      if (!rst && resp_en && mem_q.size() > 0) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = mem_q.pop_front() ^ 32'hA5A5_A5A5;
      end else begin
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
      end
    end
  end

  // Monitor: every instruction accepted by decode must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.if_valid_o && bus.if_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: got pc %h want none",
                   bus.if_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pc", bus.if_pc_o, e.pc);
          chk("mon_instr", bus.if_instr_o, e.instr);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.imem_gnt_i    = 1'b0;
    bus.if_ready_i    = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
    chk("rst_addr", bus.imem_addr_o, 32'h80);
    chk("rst_valid", {31'b0, bus.if_valid_o}, 32'd0);
    chk("rst_pc", bus.if_pc_o, 32'd0);
    chk("rst_instr", bus.if_instr_o, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: streaming fetch
    bus.if_ready_i = 1'b1;
    expect_pc(32'h80);
    issue(1, "t1_issue0");
    wait_valid("t1_first_wait");
    chk("t1_first_pc", bus.if_pc_o, 32'h80);
    chk("t1_first_instr", bus.if_instr_o, 32'hA5A5_A525);
    for (int i = 1; i < 8; i++) expect_pc(32'h80 + 32'(4 * i));
    issue(7, "t1_issue");
    drain("t1_drain");

    // 2: decode stalled, buffer fills to depth
    apply_reset();
    resp_en = 1'b1;
    bus.imem_gnt_i = 1'b1;
    repeat (8) @(negedge clk);
    chk("t2_req_low", {31'b0, bus.imem_req_o}, 32'd0);
    chk("t2_valid", {31'b0, bus.if_valid_o}, 32'd1);
    chk("t2_head_pc", bus.if_pc_o, 32'h80);
    chk("t2_grants", 32'(gcnt), 32'd2);
    @(posedge clk); #1;
    bus.imem_gnt_i = 1'b0;
    expect_pc(32'h80);
    expect_pc(32'h84);
    bus.if_ready_i = 1'b1;
    begin
      int b = 0;
      do begin
        @(negedge clk);
        b++;
      end while (!bus.imem_req_o && b < 20);
      chk("t2_resume_req", {31'b0, bus.imem_req_o}, 32'd1);
      chk("t2_resume_addr", bus.imem_addr_o, 32'h88);
    end
    drain("t2_drain");

    // 3: grant withheld, request held stable
    apply_reset();
    bus.if_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_req", {31'b0, bus.imem_req_o}, 32'd1);
      chk("t3_hold_addr", bus.imem_addr_o, 32'h80);
    end
    expect_pc(32'h80);
    issue(1, "t3_issue");
    @(negedge clk);
    chk("t3_next_addr", bus.imem_addr_o, 32'h84);
    drain("t3_drain");

    // 4: redirect with two requests in flight
    apply_reset();
    bus.if_ready_i = 1'b1;
    expect_pc(32'h80);
    issue(1, "t4_issue0");
    drain("t4_drain0");
    resp_en = 1'b0;
    issue(2, "t4_issue2");
    @(posedge clk); #1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h202;
    @(negedge clk);
    chk("t4_redir_req", {31'b0, bus.imem_req_o}, 32'd0);
    chk("t4_redir_valid", {31'b0, bus.if_valid_o}, 32'd0);
    @(posedge clk); #1;
    bus.redirect_i = 1'b0;
    @(negedge clk);
    chk("t4_target_addr", bus.imem_addr_o, 32'h200);
    chk("t4_no_credit", {31'b0, bus.imem_req_o}, 32'd0);
    resp_en = 1'b1;
    expect_pc(32'h200);
    issue(1, "t4_issue_tgt");
    drain("t4_drain");

    // 5: redirect coincident with rvalid and ready
    apply_reset();
    resp_en = 1'b1;
    issue(1, "t5_issue0");
    repeat (3) @(negedge clk);
    chk("t5_buffered", {31'b0, bus.if_valid_o}, 32'd1);
    resp_en = 1'b0;
    issue(1, "t5_issue1");
    @(negedge clk);
    resp_en = 1'b1;
    @(posedge clk); #1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h300;
    bus.if_ready_i    = 1'b1;
    @(negedge clk);
    chk("t5_redir_valid", {31'b0, bus.if_valid_o}, 32'd0);
    chk("t5_redir_req", {31'b0, bus.imem_req_o}, 32'd0);
    @(posedge clk); #1;
    bus.redirect_i = 1'b0;
    @(negedge clk);
    chk("t5_flushed", {31'b0, bus.if_valid_o}, 32'd0);
    chk("t5_target_req", {31'b0, bus.imem_req_o}, 32'd1);
    chk("t5_target_addr", bus.imem_addr_o, 32'h300);
    expect_pc(32'h300);
    issue(1, "t5_issue_tgt");
    drain("t5_drain");

    // 6: asynchronous reset with buffer full
    apply_reset();
    issue(2, "t6_issue");
    repeat (3) @(negedge clk);
    chk("t6_full_valid", {31'b0, bus.if_valid_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'b0, bus.if_valid_o}, 32'd0);
    chk("t6_rst_pc", bus.if_pc_o, 32'd0);
    chk("t6_rst_instr", bus.if_instr_o, 32'd0);
    chk("t6_rst_req", {31'b0, bus.imem_req_o}, 32'd0);
    chk("t6_rst_addr", bus.imem_addr_o, 32'h80);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.if_ready_i = 1'b1;
    @(negedge clk);
    chk("t6_restart_addr", bus.imem_addr_o, 32'h80);
    expect_pc(32'h80);
    expect_pc(32'h84);
    issue(2, "t6_issue_post");
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
